binary_to_bcd: RTL and testbench

Sequential binary-to-BCD converter that feeds the `four_digit_display` multiplexer directly upstream. It accepts an unsigned binary value on a start strobe and runs an iterative shift-add-3 (double-dabble) conversion, one bit per clock. When the conversion completes it updates four held BCD digit outputs that wire straight onto `digit0`..`digit3` of the display. Inputs above 9999 saturate to 9999 and raise an overflow flag.

---
 rtl/binary_to_bcd.sv | 95 +++++++++
 tb/tb_binary_to_bcd.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd.sv
// Iterative double-dabble converter: one binary bit per clock into four held BCD
// digits, saturating at 9999 with an overflow flag.

module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

module binary_to_bcd #(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIN_WIDTH-1:0] value,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [3:0]           digit0,
  output logic [3:0]           digit1,
  output logic [3:0]           digit2,
  output logic [3:0]           digit3
);
  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] bin_sr;
  logic [3:0][3:0]      bcd_sr;
  logic [3:0][3:0]      bcd_adj;
  logic [15:0]          adj_flat;
  logic [3:0][3:0]      bcd_next;
  logic [CW-1:0]        cnt;
  logic                 ovf;
  logic [31:0]          value_ext;

  for (genvar i = 0; i < 4; i++) begin : g_nib
    bcd_add3 u_add3 (.nib(bcd_sr[i]), .adj(bcd_adj[i]));
  end

  assign adj_flat  = bcd_adj;
  assign bcd_next  = {adj_flat[14:0], bin_sr[BIN_WIDTH-1]};
  assign value_ext = 32'(value);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      digit0   <= '0;
      digit1   <= '0;
      digit2   <= '0;
      digit3   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= value;
            bcd_sr <= '0;
            cnt    <= CW'(BIN_WIDTH);
            ovf    <= (value_ext > 32'd9999);
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr <= bin_sr << 1;
          bcd_sr <= bcd_next;
          cnt    <= cnt - CW'(1);
          // Final shift: publish straight from the combinational result.
          if (cnt == CW'(1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            overflow <= ovf;
            digit0   <= ovf ? 4'd9 : bcd_next[0];
            digit1   <= ovf ? 4'd9 : bcd_next[1];
            digit2   <= ovf ? 4'd9 : bcd_next[2];
            digit3   <= ovf ? 4'd9 : bcd_next[3];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd: directed scenarios plus random values
// compared against an arithmetic decimal reference.

module tb_binary_to_bcd;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] value = '0;
  logic        start = 1'b0;
  logic        busy, done, overflow;
  logic [3:0]  digit0, digit1, digit2, digit3;

  int vectors = 0;
  int miscompares = 0;

  binary_to_bcd #(.BIN_WIDTH(14)) dut (
    .clk(clk), .rst(rst), .value(value), .start(start),
    .busy(busy), .done(done), .overflow(overflow),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_digits(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] shown();
    return {digit3, digit2, digit1, digit0};
  endfunction

  // Drives one start pulse and waits for done; returns what the display saw.
  task automatic convert(input int v, output logic [15:0] got, output logic got_ovf,
                         output int busy_cycles, output bit ok);
    logic [31:0] vv;
    vv = v;
    @(negedge clk);
    value = vv[13:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin ok = 1'b1; break; end
      if (busy) busy_cycles++;
      @(posedge clk); #1;
    end
    got = shown();
    got_ovf = overflow;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({busy, done, overflow} !== 3'b000 || shown() !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset: busy/done/ovf=%b digits=%h, required 000 / 0000",
               {busy, done, overflow}, shown());
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_nominal();
    logic [15:0] got; logic g_ovf; int bc; bit ok;
    convert(1234, got, g_ovf, bc, ok);
    vectors++;
    if (!ok || bc != 14 || got !== 16'h1234 || g_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal: done=%0b busy_cycles=%0d digits=%h ovf=%b, required 1 14 1234 0",
               ok, bc, got, g_ovf);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_with_done: busy=%b, required 0", busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || shown() !== 16'h1234) begin
      miscompares++;
      $display("FAIL done_width: done=%b digits=%h, required 0 1234", done, shown());
    end
  endtask

  task automatic test_boundaries();
    int vals[3] = '{0, 9999, 1000};
    logic [15:0] exp[3] = '{16'h0000, 16'h9999, 16'h1000};
    logic [15:0] got; logic g_ovf; int bc; bit ok;
    foreach (vals[i]) begin
      convert(vals[i], got, g_ovf, bc, ok);
      vectors++;
      if (!ok || got !== exp[i] || g_ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL boundary %0d: done=%0b digits=%h ovf=%b, required 1 %h 0",
                 vals[i], ok, got, g_ovf, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int vals[3] = '{10000, 16383, 42};
    logic [15:0] exp[3] = '{16'h9999, 16'h9999, 16'h0042};
    logic        eov[3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] got; logic g_ovf; int bc; bit ok;
    foreach (vals[i]) begin
      convert(vals[i], got, g_ovf, bc, ok);
      vectors++;
      if (!ok || got !== exp[i] || g_ovf !== eov[i]) begin
        miscompares++;
        $display("FAIL overflow %0d: done=%0b digits=%h ovf=%b, required 1 %h %b",
                 vals[i], ok, got, g_ovf, exp[i], eov[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int n_done = 0;
    logic [15:0] first = 16'hxxxx;
    @(negedge clk); value = 14'd5678; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); value = 14'd1111; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        if (n_done == 0) first = shown();
        n_done++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (n_done != 1 || first !== 16'h5678) begin
      miscompares++;
      $display("FAIL start_while_busy: dones=%0d digits=%h, required 1 5678", n_done, first);
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int t_done[$];
    logic [15:0] res[$];
    @(negedge clk); value = 14'd1; start = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 60; t++) begin
      if (t % 15 == 0) value = 14'(t / 15 + 2);
      if (done) begin t_done.push_back(t); res.push_back(shown()); n_done++; end
      if (t == 44) start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    vectors++;
    if (n_done != 3) begin
      miscompares++;
      $display("FAIL back_to_back_count: dones=%0d, required 3", n_done);
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (t_done[k] != 14 + 15 * k || res[k] !== ref_digits(k + 1)) begin
          miscompares++;
          $display("FAIL back_to_back %0d: cycle=%0d digits=%h, required %0d %h",
                   k, t_done[k], res[k], 14 + 15 * k, ref_digits(k + 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    logic [15:0] got; logic g_ovf; int bc; bit ok;
    @(negedge clk); value = 14'd4321; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, overflow} !== 3'b000 || shown() !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid: busy/done/ovf=%b digits=%h, required 000 0000",
               {busy, done, overflow}, shown());
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    vectors++;
    if (n_done != 0 || shown() !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid_publish: dones=%0d digits=%h, required 0 0000", n_done, shown());
    end
    convert(4321, got, g_ovf, bc, ok);
    vectors++;
    if (!ok || got !== 16'h4321 || g_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_recover: done=%0b digits=%h ovf=%b, required 1 4321 0",
               ok, got, g_ovf);
    end
  endtask

  task automatic test_random();
    logic [15:0] got; logic g_ovf; int bc; bit ok; int v;
    for (int n = 0; n < 40; n++) begin
      v = (n % 4 == 0) ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, 16383));
      convert(v, got, g_ovf, bc, ok);
      vectors++;
      if (!ok || bc != 14 || got !== ref_digits(v) || g_ovf !== (v > 9999)) begin
        miscompares++;
        $display("FAIL random %0d: done=%0b busy_cycles=%0d digits=%h ovf=%b, required 1 14 %h %b",
                 v, ok, bc, got, g_ovf, ref_digits(v), (v > 9999));
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_boundaries();
    test_overflow();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
